matvec_stream_mac: RTL and testbench

MATVEC_STREAM_MAC -- requirements
Module: matvec_stream_mac

---
 rtl/matvec_pkg.sv | 21 ++
 rtl/mac_unit.sv | 39 +++
 rtl/matvec_stream_mac.sv | 153 +++++++++++++++
 tb/tb_matvec_stream_mac.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// Shared widths, state encoding and saturation mode constants for the streaming mat-vec MAC.
package matvec_pkg;

    // Accumulator width: a full-precision product plus growth for N terms.
    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        StNoTheta,
        StRun
    } state_e;

    localparam bit SatWrap  = 1'b0;
    localparam bit SatClamp = 1'b1;

endpackage

// File: rtl/mac_unit.sv
// Signed DW x DW multiply feeding an AW-bit accumulator; sum_o is the accumulator plus this product.
module mac_unit #(
    parameter int DW = 16,
    parameter int AW = 34
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    output logic signed [AW-1:0] sum_o
);

    logic signed [AW-1:0]   acc_q, acc_d;
    logic signed [2*DW-1:0] prod;

    assign prod  = (2*DW)'(a_i) * (2*DW)'(b_i);
    assign sum_o = acc_q + AW'(prod);

    // Clear wins over accumulate so the closing beat of a row leaves a zero accumulator.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matvec_stream_mac.sv
// Streams a row-major M x N matrix against a latched theta vector, emitting one dot product per row.
module matvec_stream_mac
    import matvec_pkg::*;
#(
    parameter int M   = 20,
    parameter int N   = 3,
    parameter int DW  = 16,
    parameter int OW  = 32,
    parameter bit SAT = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      theta_load,
    input  logic [N*DW-1:0]           theta_in,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DW-1:0]             s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [OW-1:0]             m_data,
    output logic [idx_width(M)-1:0]   m_row,
    output logic                      m_last,
    output logic                      m_sat
);

    localparam int AW = acc_width(DW, N);
    localparam int CW = idx_width(N);
    localparam int RW = idx_width(M);

    localparam logic [CW-1:0] ColLast = CW'(N - 1);
    localparam logic [RW-1:0] RowLast = RW'(M - 1);
    localparam logic signed [AW-1:0] MaxPos = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW-1:0] MinNeg = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    state_e            state_q, state_d;
    logic [N*DW-1:0]   theta_q, theta_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              m_valid_q, m_valid_d;
    logic [OW-1:0]     m_data_q, m_data_d;
    logic [RW-1:0]     m_row_q, m_row_d;
    logic              m_last_q, m_last_d;
    logic              m_sat_q, m_sat_d;

    logic              load_ok, beat, last_beat;
    logic [DW-1:0]     theta_elem;
    logic signed [AW-1:0] sum;
    logic              over, under;
    logic [OW-1:0]     res;

    mac_unit #(
        .DW (DW),
        .AW (AW)
    ) u_mac (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (beat),
        .clr_i (last_beat),
        .a_i   (s_data),
        .b_i   (theta_elem),
        .sum_o (sum)
    );

    always_comb begin
        // In RUN a reload is only safe before the first beat of a frame.
        load_ok   = theta_load && (state_q == StNoTheta || (col_q == '0 && row_q == '0));
        s_ready   = (state_q == StRun) && !(m_valid_q && !m_ready) && !load_ok;
        beat      = s_valid && s_ready;
        last_beat = beat && (col_q == ColLast);

        theta_elem = '0;
        for (int i = 0; i < N; i++) begin
            if (col_q == CW'(i)) begin
                theta_elem = theta_q[(N-1-i)*DW +: DW];
            end
        end

        over  = sum > MaxPos;
        under = sum < MinNeg;
        res   = sum[OW-1:0];
        if (SAT == SatClamp) begin
            if (over) begin
                res = MaxPos[OW-1:0];
            end else if (under) begin
                res = MinNeg[OW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        theta_d   = theta_q;
        col_d     = col_q;
        row_d     = row_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_row_d   = m_row_q;
        m_last_d  = m_last_q;
        m_sat_d   = m_sat_q;

        if (load_ok) begin
            theta_d = theta_in;
            state_d = StRun;
        end

        if (beat) begin
            col_d = (col_q == ColLast) ? '0 : col_q + CW'(1);
        end

        // A consumed result is replaced in the same cycle, keeping one row per N beats.
        if (last_beat) begin
            row_d     = (row_q == RowLast) ? '0 : row_q + RW'(1);
            m_valid_d = 1'b1;
            m_data_d  = res;
            m_row_d   = row_q;
            m_last_d  = (row_q == RowLast);
            m_sat_d   = over || under;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StNoTheta;
            theta_q   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_row_q   <= '0;
            m_last_q  <= 1'b0;
            m_sat_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            theta_q   <= theta_d;
            col_q     <= col_d;
            row_q     <= row_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_row_q   <= m_row_d;
            m_last_q  <= m_last_d;
            m_sat_q   <= m_sat_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_row   = m_row_q;
    assign m_last  = m_last_q;
    assign m_sat   = m_sat_q;

endmodule

// File: tb/tb_matvec_stream_mac.sv
// Bench for matvec_stream_mac: a wrapping and a clamping instance share stimulus, checked by scoreboard.
module tb_matvec_stream_mac;

    localparam int M  = 2;
    localparam int N  = 3;
    localparam int DW = 16;
    localparam int OW = 32;

    typedef logic [2:0][15:0] vec3_t;

    typedef struct {
        vec3_t             th;
        vec3_t             x0;
        vec3_t             x1;
        logic signed [31:0] w0;
        logic signed [31:0] c0;
        logic              f0;
        logic signed [31:0] w1;
        logic signed [31:0] c1;
        logic              f1;
    } frame_t;

    typedef struct {
        logic signed [31:0] w;
        logic signed [31:0] c;
        logic              row;
        logic              last;
        logic              f;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst, theta_load, s_valid, m_ready;
    logic [N*DW-1:0]  theta_in;
    logic [DW-1:0]    s_data;

    logic             s_ready_w, m_valid_w, m_row_w, m_last_w, m_sat_w;
    logic [OW-1:0]    m_data_w;
    logic             s_ready_s, m_valid_s, m_row_s, m_last_s, m_sat_s;
    logic [OW-1:0]    m_data_s;

    int     checks = 0;
    int     errors = 0;
    exp_t   sb[$];
    exp_t   e_mon;
    logic   exp_row = 1'b0;
    frame_t tbl[5];

    always #5 clk = ~clk;

    matvec_stream_mac #(.M(M), .N(N), .DW(DW), .OW(OW), .SAT(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .theta_load (theta_load),
        .theta_in   (theta_in),
        .s_valid    (s_valid),
        .s_ready    (s_ready_w),
        .s_data     (s_data),
        .m_valid    (m_valid_w),
        .m_ready    (m_ready),
        .m_data     (m_data_w),
        .m_row      (m_row_w),
        .m_last     (m_last_w),
        .m_sat      (m_sat_w)
    );

    matvec_stream_mac #(.M(M), .N(N), .DW(DW), .OW(OW), .SAT(1'b1)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .theta_load (theta_load),
        .theta_in   (theta_in),
        .s_valid    (s_valid),
        .s_ready    (s_ready_s),
        .s_data     (s_data),
        .m_valid    (m_valid_s),
        .m_ready    (m_ready),
        .m_data     (m_data_s),
        .m_row      (m_row_s),
        .m_last     (m_last_s),
        .m_sat      (m_sat_s)
    );

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input logic signed [31:0] w, input logic signed [31:0] c, input logic f);
        exp_t e;
        e.w    = w;
        e.c    = c;
        e.row  = exp_row;
        e.last = (exp_row == 1'b1);
        e.f    = f;
        sb.push_back(e);
        exp_row = ~exp_row;
    endtask

    task automatic push_model(input vec3_t th, input vec3_t x);
        longint s;
        logic signed [31:0] w, c;
        logic f;
        s = 0;
        for (int j = 0; j < 3; j++) begin
            s += longint'($signed(th[2-j])) * longint'($signed(x[2-j]));
        end
        w = s[31:0];
        f = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        c = (s > 64'sd2147483647) ? 32'sh7fffffff : (s < -64'sd2147483648) ? 32'sh80000000 : w;
        push(w, c, f);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        n = 0;
        @(negedge clk);
        while (!s_ready_w && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("beat_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_valid    = 1'b0;
        theta_load = 1'b0;
    endtask

    task automatic send_row(input vec3_t x);
        for (int j = 0; j < 3; j++) beat(x[2-j]);
    endtask

    task automatic load(input vec3_t th);
        theta_load = 1'b1;
        theta_in   = th;
        tick();
        theta_load = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("drain_timeout", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid_w && m_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e_mon = sb.pop_front();
                chk("wrap_data", $signed(m_data_w), e_mon.w);
                chk("clamp_data", $signed(m_data_s), e_mon.c);
                chk("row", m_row_w, e_mon.row);
                chk("last", m_last_w, e_mon.last);
                chk("wrap_sat", m_sat_w, e_mon.f);
                chk("clamp_sat", m_sat_s, e_mon.f);
                chk("clamp_valid", m_valid_s, 1);
            end
        end
    end

    initial begin
        vec3_t a, b, bn, r0, r1;
        a  = {16'sd1, 16'sd2, 16'sd3};
        b  = {16'sd5, 16'sd5, 16'sd5};
        bn = {16'sd2, 16'sd0, -16'sd1};
        r0 = {16'sd1, 16'sd1, 16'sd1};
        r1 = {-16'sd1, 16'sd0, 16'sd2};

        tbl[0] = '{th: a, x0: r0, x1: r1,
                   w0: 32'sd6, c0: 32'sd6, f0: 1'b0, w1: 32'sd5, c1: 32'sd5, f1: 1'b0};
        tbl[1] = '{th: {-16'sd2, 16'sd5, 16'sd0}, x0: {16'sd3, 16'sd4, 16'sd7},
                   x1: {-16'sd100, 16'sd200, -16'sd5},
                   w0: 32'sd14, c0: 32'sd14, f0: 1'b0, w1: 32'sd1200, c1: 32'sd1200, f1: 1'b0};
        tbl[2] = '{th: {16'h7fff, 16'h7fff, 16'h7fff}, x0: {16'h7fff, 16'h7fff, 16'h7fff},
                   x1: {16'h8000, 16'h8000, 16'h8000},
                   w0: -32'sd1073938429, c0: 32'sh7fffffff, f0: 1'b1,
                   w1: 32'sd1073840128, c1: 32'sh80000000, f1: 1'b1};
        tbl[3] = '{th: {16'h8000, 16'h8000, 16'h8000}, x0: {16'h8000, 16'h8000, 16'h8000},
                   x1: {16'h0, 16'h0, 16'h0},
                   w0: -32'sd1073741824, c0: 32'sh7fffffff, f0: 1'b1,
                   w1: 32'sd0, c1: 32'sd0, f1: 1'b0};
        tbl[4] = '{th: {16'sd7, -16'sd3, 16'sd1}, x0: {16'sd10, 16'sd10, 16'sd10},
                   x1: {-16'sd1, -16'sd1, -16'sd1},
                   w0: 32'sd50, c0: 32'sd50, f0: 1'b0, w1: -32'sd5, c1: -32'sd5, f1: 1'b0};

        rst = 1'b1; theta_load = 1'b0; theta_in = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        s_valid = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", s_ready_w, 0);
        chk("rst_m_valid", m_valid_w, 0);
        chk("rst_m_data", m_data_w, 0);
        chk("rst_m_row", m_row_w, 0);
        chk("rst_m_last", m_last_w, 0);
        chk("rst_m_sat", m_sat_s, 0);
        tick();
        s_valid = 1'b0;

        for (int i = 0; i < 5; i++) begin
            load(tbl[i].th);
            push(tbl[i].w0, tbl[i].c0, tbl[i].f0);
            send_row(tbl[i].x0);
            push(tbl[i].w1, tbl[i].c1, tbl[i].f1);
            send_row(tbl[i].x1);
        end
        drain();

        // Backpressure after the first result of a frame.
        load(a);
        push_model(a, r0);
        send_row(r0);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'hffff;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_s_ready", s_ready_w, 0);
            chk("stall_m_valid", m_valid_w, 1);
            chk("stall_m_data", $signed(m_data_w), 6);
            tick();
        end
        m_ready = 1'b1;
        push_model(a, r1);
        send_row(r1);
        drain();

        // Mid-row theta_load must be ignored.
        load(a);
        push_model(a, r0);
        beat(16'd1);
        theta_load = 1'b1;
        theta_in   = b;
        beat(16'd1);
        beat(16'd1);
        push_model(a, r1);
        send_row(r1);
        drain();

        // Load at a frame boundary beats a coincident s_valid.
        push_model(bn, {16'sd4, 16'sd5, 16'sd6});
        theta_load = 1'b1;
        theta_in   = bn;
        s_valid    = 1'b1;
        s_data     = 16'd4;
        @(negedge clk);
        chk("load_wins_s_ready", s_ready_w, 0);
        tick();
        theta_load = 1'b0;
        @(negedge clk);
        chk("beat_after_load", s_ready_w, 1);
        tick();
        s_valid = 1'b0;
        beat(16'd5);
        beat(16'd6);
        push_model(bn, r0);
        send_row(r0);
        drain();

        // Reset mid-row discards the partial sum and requires a fresh theta.
        beat(16'd1);
        beat(16'd1);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'd1;
        tick();
        rst     = 1'b0;
        exp_row = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_m_valid", m_valid_w, 0);
            chk("post_rst_s_ready", s_ready_w, 0);
            tick();
        end
        s_valid = 1'b0;
        load(a);
        push_model(a, r0);
        send_row(r0);
        push_model(a, r1);
        send_row(r1);
        drain();

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
